// File: rtl/ram_1wnr_sync_no_collision.sv
// Single-write, multi-read synchronous RAM with one-cycle registered read responses.
// A read that hits the address being written either stalls or forwards the write data.
module ram_1wnr_sync_no_collision #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int NUM_RD = 2,
    parameter int BYPASS = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_a,
    input  logic [ADDR_W-1:0]        wr_addr_a,
    input  logic [DATA_W-1:0]        wr_data_a,
    output logic                     wr_rdy_a,
    input  logic [NUM_RD-1:0]        rd_req_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_req_addr,
    output logic [NUM_RD-1:0]        rd_req_rdy,
    output logic [NUM_RD-1:0]        rd_resp_val,
    output logic [NUM_RD*DATA_W-1:0] rd_resp_data,
    input  logic [NUM_RD-1:0]        rd_resp_rdy
);

    logic [DATA_W-1:0]        mem_r [DEPTH];
    logic [NUM_RD-1:0]        resp_val_r;
    logic [NUM_RD*DATA_W-1:0] resp_data_r;

    logic [ADDR_W-1:0]        rd_addr_s [NUM_RD];
    logic [NUM_RD-1:0]        addr_hit_s;
    logic [NUM_RD-1:0]        req_rdy_s;
    logic [NUM_RD-1:0]        accept_s;

    // Ready is built from the write address match rather than the full collision term,
    // so a port's ready never depends on its own request enable.
    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_addr_s[i]  = rd_req_addr[i*ADDR_W +: ADDR_W];
            addr_hit_s[i] = wr_en_a && (rd_addr_s[i] == wr_addr_a);
            req_rdy_s[i]  = !rst && (!resp_val_r[i] || rd_resp_rdy[i])
                            && ((BYPASS != 0) || !addr_hit_s[i]);
            accept_s[i]   = rd_req_en[i] && req_rdy_s[i];
        end
    end

    // Memory array: no reset, contents survive rst; writes are ignored while rst is high.
    always_ff @(posedge clk) begin
        if (wr_en_a && !rst) begin
            mem_r[wr_addr_a] <= wr_data_a;
        end
    end

    // Per-port response registers: load on accept, clear on drain, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_val_r  <= {NUM_RD{1'b0}};
            resp_data_r <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            for (int i = 0; i < NUM_RD; i++) begin
                if (accept_s[i]) begin
                    resp_val_r[i] <= 1'b1;
                    if ((BYPASS != 0) && addr_hit_s[i]) begin
                        resp_data_r[i*DATA_W +: DATA_W] <= wr_data_a;
                    end else begin
                        resp_data_r[i*DATA_W +: DATA_W] <= mem_r[rd_addr_s[i]];
                    end
                end else if (rd_resp_rdy[i]) begin
                    resp_val_r[i] <= 1'b0;
                end else begin
                    resp_val_r[i] <= resp_val_r[i];
                end
            end
        end
    end

    assign wr_rdy_a     = !rst;
    assign rd_req_rdy   = req_rdy_s;
    assign rd_resp_val  = resp_val_r;
    assign rd_resp_data = resp_data_r;

endmodule

// File: tb/tb_ram_1wnr_sync_no_collision.sv
// Bench for ram_1wnr_sync_no_collision: stall and forward variants driven in lockstep,
// directed scenarios with literal expectations followed by randomized traffic against a model.
module tb_ram_1wnr_sync_no_collision;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;
    logic [1:0]  resp_rdy;

    logic [1:0]  dval [2];
    logic [1:0]  drdy [2];
    logic [63:0] ddata [2];
    logic        dwr [2];

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_mem [8];
    logic        m_val [2][2];
    logic [31:0] m_data [2][2];

    always #5 clk = ~clk;

    ram_1wnr_sync_no_collision #(.DATA_W(32), .DEPTH(8), .NUM_RD(2), .BYPASS(0)) u_stall (
        .clk(clk), .rst(rst),
        .wr_en_a(wr_en), .wr_addr_a(wr_addr), .wr_data_a(wr_data), .wr_rdy_a(dwr[0]),
        .rd_req_en(rd_en), .rd_req_addr(rd_addr), .rd_req_rdy(drdy[0]),
        .rd_resp_val(dval[0]), .rd_resp_data(ddata[0]), .rd_resp_rdy(resp_rdy)
    );

    ram_1wnr_sync_no_collision #(.DATA_W(32), .DEPTH(8), .NUM_RD(2), .BYPASS(1)) u_fwd (
        .clk(clk), .rst(rst),
        .wr_en_a(wr_en), .wr_addr_a(wr_addr), .wr_data_a(wr_data), .wr_rdy_a(dwr[1]),
        .rd_req_en(rd_en), .rd_req_addr(rd_addr), .rd_req_rdy(drdy[1]),
        .rd_resp_val(dval[1]), .rd_resp_data(ddata[1]), .rd_resp_rdy(resp_rdy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Hand-written memory image after the directed writes.
    function automatic logic [31:0] exp_mem(input int a);
        case (a)
            2:       return 32'hDEAD_0005;
            3:       return 32'hA5A5_0003;
            5:       return 32'h0000_0011;
            default: return 32'h1000_0000 + 32'(a);
        endcase
    endfunction

    // Behavioural model: checks outputs mid-cycle, then advances on the inputs seen now.
    always @(negedge clk) begin : model_check
        logic [2:0] a;
        logic       hit, er, acc;
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 2; i++) begin
                a   = rd_addr[i*3 +: 3];
                hit = wr_en && (a == wr_addr);
                er  = !rst && (!m_val[b][i] || resp_rdy[i]) && (b == 1 || !hit);
                if (rd_en[i] || !hit) chk("model_rdy", 64'(drdy[b][i]), 64'(er));
                chk("model_val", 64'(dval[b][i]), 64'(rst ? 1'b0 : m_val[b][i]));
                if (rst) chk("model_rst_data", 64'(ddata[b][i*32 +: 32]), 64'd0);
                else if (m_val[b][i]) chk("model_data", 64'(ddata[b][i*32 +: 32]), 64'(m_data[b][i]));
                acc = rd_en[i] && er;
                if (rst) begin
                    m_val[b][i]  <= 1'b0;
                    m_data[b][i] <= 32'd0;
                end else if (acc) begin
                    m_val[b][i]  <= 1'b1;
                    m_data[b][i] <= (b == 1 && hit) ? wr_data : m_mem[a];
                end else if (resp_rdy[i]) begin
                    m_val[b][i]  <= 1'b0;
                end
            end
            chk("model_wr_rdy", 64'(dwr[b]), 64'(!rst));
        end
        if (wr_en && !rst) m_mem[wr_addr] <= wr_data;
    end

    initial begin
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 32'd0;
        rd_en = 2'b00; rd_addr = 6'd0; resp_rdy = 2'b11;

        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            chk("reset_val", 64'(dval[b]), 64'd0);
            chk("reset_data", ddata[b], 64'd0);
            chk("reset_rdy", 64'(drdy[b]), 64'd0);
            chk("reset_wr_rdy", 64'(dwr[b]), 64'd0);
        end
        nxt(); rst = 1'b0;
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("post_reset_rdy", 64'(drdy[b]), 64'd3);

        for (int k = 0; k < 8; k++) begin
            nxt(); wr_en = 1'b1; wr_addr = 3'(k); wr_data = 32'h1000_0000 + 32'(k);
        end

        // Write then read back one cycle later.
        nxt(); wr_addr = 3'd3; wr_data = 32'hA5A5_0003;
        nxt(); wr_en = 1'b0; rd_en = 2'b01; rd_addr = 6'd3;
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("wr_rd_accept", 64'(drdy[b][0]), 64'd1);
        nxt(); rd_en = 2'b00;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            chk("wr_rd_val", 64'(dval[b][0]), 64'd1);
            chk("wr_rd_data", 64'(ddata[b][31:0]), 64'hA5A5_0003);
        end

        // Same-cycle collision on port 1: stall variant refuses, forward variant accepts.
        nxt(); wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'h11; rd_en = 2'b10; rd_addr = {3'd5, 3'd0};
        @(negedge clk);
        chk("stall_collision_rdy", 64'(drdy[0][1]), 64'd0);
        chk("fwd_collision_rdy", 64'(drdy[1][1]), 64'd1);
        nxt(); wr_en = 1'b0;
        @(negedge clk);
        chk("stall_retry_rdy", 64'(drdy[0][1]), 64'd1);
        chk("fwd_resp_val", 64'(dval[1][1]), 64'd1);
        chk("fwd_resp_data", 64'(ddata[1][63:32]), 64'h11);
        nxt(); rd_en = 2'b00;
        @(negedge clk);
        chk("stall_retry_val", 64'(dval[0][1]), 64'd1);
        chk("stall_retry_data", 64'(ddata[0][63:32]), 64'h11);

        // Backpressure on port 0 while the same address is rewritten.
        nxt(); rd_en = 2'b01; rd_addr = 6'd2; resp_rdy = 2'b10;
        for (int h = 0; h < 4; h++) begin
            nxt(); rd_en = 2'b00; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hDEAD_0002 + 32'(h);
            @(negedge clk);
            for (int b = 0; b < 2; b++) begin
                chk("hold_val", 64'(dval[b][0]), 64'd1);
                chk("hold_data", 64'(ddata[b][31:0]), 64'h1000_0002);
                chk("hold_rdy", 64'(drdy[b][0]), 64'd0);
            end
        end
        nxt(); wr_en = 1'b0; resp_rdy = 2'b11;
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("drain_rdy", 64'(drdy[b][0]), 64'd1);
        nxt();
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("drained_val", 64'(dval[b][0]), 64'd0);

        // Both ports stream addresses 0..7 back to back.
        for (int k = 0; k < 9; k++) begin
            nxt(); rd_en = (k < 8) ? 2'b11 : 2'b00; rd_addr = {3'(k), 3'(k)};
            @(negedge clk);
            if (k > 0) begin
                for (int b = 0; b < 2; b++) begin
                    chk("stream_val", 64'(dval[b]), 64'd3);
                    chk("stream_data", ddata[b], {exp_mem(k-1), exp_mem(k-1)});
                end
            end
        end

        // Reset during a stalled response; memory survives.
        nxt(); rd_en = 2'b01; rd_addr = 6'd4; resp_rdy = 2'b10;
        nxt(); rd_en = 2'b00;
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("pre_rst_data", 64'(ddata[b][31:0]), 64'h1000_0004);
        nxt(); rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd4; wr_data = 32'hBAD0_BAD0; rd_en = 2'b11;
        #1;
        for (int b = 0; b < 2; b++) chk("async_rst_val", 64'(dval[b][0]), 64'd0);
        nxt(); rst = 1'b0; wr_en = 1'b0; rd_en = 2'b00; resp_rdy = 2'b11;
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            chk("after_rst_val", 64'(dval[b]), 64'd0);
            chk("after_rst_rdy", 64'(drdy[b]), 64'd3);
        end
        nxt(); rd_en = 2'b11; rd_addr = {3'd3, 3'd4};
        nxt(); rd_en = 2'b00;
        @(negedge clk);
        for (int b = 0; b < 2; b++) chk("mem_kept", ddata[b], {32'hA5A5_0003, 32'h1000_0004});

        // Randomized traffic, with collisions and occasional resets.
        for (int n = 0; n < 2000; n++) begin
            nxt();
            rst     = ($urandom_range(0, 199) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = $urandom;
            rd_en   = 2'($urandom_range(0, 3));
            rd_addr = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) rd_addr[2:0] = wr_addr;
            if ($urandom_range(0, 2) == 0) rd_addr[5:3] = wr_addr;
            resp_rdy = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
        end

        nxt(); rst = 1'b0; wr_en = 1'b0; rd_en = 2'b00; resp_rdy = 2'b11;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
